id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter REG_AW, 5, register address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  in  REG_AW each  decoded register fields.
REQ-007 id_a, id_b  in  DATA_W each  register-file read data for rs, rt (A, B).
REQ-008 id_imm  in  16  raw immediate.
REQ-009 id_ctrl  in  8  decoded control: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg, [4] alusrc, [5] regdst, [7:6] aluop.
REQ-010 wb_regwrite, wb_addr, wb_data  in  1 / REG_AW / DATA_W  write-back port driving the register file this cycle.
REQ-011 flush  in  1  squash the decode instruction (taken branch/jump).
REQ-012 stall  out  1  combinational; hold PC and IF/ID register.
REQ-013 ex_valid, ex_rs, ex_rt, ex_dst  out  1 / REG_AW x3  registered EX-stage fields.
REQ-014 ex_a, ex_b, ex_imm  out  DATA_W each  registered operands; ex_imm sign-extended.
REQ-015 ex_ctrl  out  8  registered control, same layout as id_ctrl.
REQ-016 bubble_cnt  out  16  registered count of inserted bubbles.

Function
REQ-017 Hazard: stall SHALL be 1 iff ex_valid and ex_ctrl[1] and ex_dst!=0 and (ex_dst==id_rs or ex_dst==id_rt) and id_valid.
REQ-018 Priority each edge: flush > stall > normal capture.
REQ-019 Normal capture (id_valid=1, no flush/stall): all ex_* load from id_* in one cycle; ex_valid=1.
REQ-020 ex_dst SHALL be id_rd when id_ctrl[5]=1, else id_rt.
REQ-021 ex_imm SHALL be {16{id_imm[15]}, id_imm}.
REQ-022 WB bypass: if wb_regwrite and wb_addr!=0 and wb_addr==id_rs, ex_a captures wb_data instead of id_a; same rule independently for id_rt/ex_b.
REQ-023 Bubble (flush, stall, or id_valid=0): ex_valid=0, ex_ctrl=0; other ex_* fields don't-care but SHALL be zero.
REQ-024 A stall SHALL last exactly one cycle for a single load-use pair, since the bubble clears ex_ctrl[1].
REQ-025 bubble_cnt increments by 1 on every edge where flush or stall forces a bubble (not id_valid=0); saturates at 0xFFFF.
REQ-026 Register 0 never triggers stall or bypass.
REQ-027 flush and stall asserted together: flush wins, stall deasserts next cycle because ex_valid=0.

Reset
REQ-028 rst=1 SHALL immediately clear all ex_* outputs and bubble_cnt to 0; stall therefore reads 0.
REQ-029 Reset mid-stall SHALL discard the stalled instruction; first post-reset edge captures normally.

Structure
REQ-030 Shared package mips_pkg SHALL hold DATA_W, REG_AW and the id_ctrl bit-index constants (CTRL_REGWRITE..CTRL_ALUOP).
REQ-031 One sub-module hazard_detect (combinational load-use compare) SHALL produce stall; all registers live in id_ex_stage.

Verification
REQ-032 Plain capture: id_rs=2,id_rt=3,id_a=5,id_b=7,id_imm=0xFFFE,regdst=1,id_rd=4 -> next edge ex_a=5, ex_b=7, ex_imm=0xFFFFFFFE, ex_dst=4, ex_valid=1.
REQ-033 WB bypass: id_rt=3, id_b=0, wb_regwrite=1, wb_addr=3, wb_data=100 -> ex_b=100; same with wb_addr=0 -> ex_b=0.
REQ-034 Load-use: load with ex_dst=6 in EX, id_rs=6 -> stall=1 one cycle, bubble inserted, bubble_cnt=1, instruction captured next edge with stall=0.
REQ-035 Flush+stall same cycle -> ex_valid=0, ex_ctrl=0, bubble_cnt+1 once, stall=0 next cycle.
REQ-036 Counter saturation: preload 0xFFFE via 2 extra forced bubbles -> bubble_cnt stops at 0xFFFF.
REQ-037 Async reset asserted between edges during stall -> all outputs 0 immediately, stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, control-bit layout and small helpers for the ID/EX stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  // Bit positions inside id_ctrl / ex_ctrl.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUOP    = 6;   // two-bit field, [7:6]

  // What the pipeline register loads on the next edge.
  typedef enum logic [1:0] {
    SEL_CAPTURE = 2'd0,   // real instruction moves into EX
    SEL_FORCED  = 2'd1,   // flush or load-use bubble (counted)
    SEL_IDLE    = 2'd2    // decode empty, bubble not counted
  } ex_sel_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of
// the instruction in decode forces a one-cycle stall.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  output logic              stall
);

  logic dst_nonzero;
  logic dst_match;

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  always_comb begin
    dst_nonzero = (ex_dst != '0);
    dst_match   = (ex_dst == id_rs) || (ex_dst == id_rt);
    stall       = id_valid && ex_valid && ex_memread && dst_nonzero && dst_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall and a
// saturating count of forced bubbles.
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [15:0]       id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic [15:0]       bubble_cnt
);

  import mips_pkg::*;

  logic              ex_valid_q,   ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_dst_q,     ex_dst_d;
  logic [DATA_W-1:0] ex_a_q,       ex_a_d;
  logic [DATA_W-1:0] ex_b_q,       ex_b_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [7:0]        ex_ctrl_q,    ex_ctrl_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  ex_sel_e           sel;
  logic              bypass_a;
  logic              bypass_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (ex_valid_q),
    .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_dst     (ex_dst_q),
    .stall      (stall)
  );

  // Pick what the pipeline register loads: flush beats stall beats capture.
  always_comb begin
    sel = SEL_CAPTURE;
    if (flush || stall) begin
      sel = SEL_FORCED;
    end else if (!id_valid) begin
      sel = SEL_IDLE;
    end
  end

  // Forward the value being written back this cycle so EX never sees stale data.
  always_comb begin
    bypass_a = wb_regwrite && (wb_addr != '0) && (wb_addr == id_rs);
    bypass_b = wb_regwrite && (wb_addr != '0) && (wb_addr == id_rt);
    opnd_a   = bypass_a ? wb_data : id_a;
    opnd_b   = bypass_b ? wb_data : id_b;
  end

  // Next-state of the EX fields; bubbles load all zeros.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_rs_d    = '0;
    ex_rt_d    = '0;
    ex_dst_d   = '0;
    ex_a_d     = '0;
    ex_b_d     = '0;
    ex_imm_d   = '0;
    ex_ctrl_d  = '0;
    if (sel == SEL_CAPTURE) begin
      ex_valid_d = 1'b1;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_dst_d   = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
      ex_a_d     = opnd_a;
      ex_b_d     = opnd_b;
      ex_imm_d   = {{(DATA_W-16){id_imm[15]}}, id_imm};
      ex_ctrl_d  = id_ctrl;
    end
  end

  // Only flush/stall bubbles are counted; an empty decode slot is not.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (sel == SEL_FORCED) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // Pipeline register and counter; reset discards any stalled instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dst_q     <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dst_q     <= ex_dst_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_dst     = ex_dst_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_a, id_b;
  logic [15:0] id_imm;
  logic [7:0]  id_ctrl;
  logic        wb_regwrite;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  int n_cmp;
  int n_bad;

  localparam logic [7:0] C_ALU  = 8'h21; // regwrite + regdst
  localparam logic [7:0] C_ALUI = 8'h01; // regwrite, dst = rt
  localparam logic [7:0] C_LOAD = 8'h1B; // regwrite+memread+memtoreg+alusrc

  id_ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_a        (id_a),
    .id_b        (id_b),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .wb_regwrite (wb_regwrite),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_dst      (ex_dst),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_imm      (ex_imm),
    .ex_ctrl     (ex_ctrl),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [7:0] ctrl);
    id_valid = v;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
    id_a     = a;
    id_b     = b;
    id_imm   = imm;
    id_ctrl  = ctrl;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    wb_regwrite = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 8'd0);
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain capture with regdst and negative immediate.
    drive(1'b1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd7, 16'hFFFE, C_ALU);
    #1 chk("cap_stall", {31'd0, stall}, 32'd0);
    step();
    chk("cap_a", ex_a, 32'd5);
    chk("cap_b", ex_b, 32'd7);
    chk("cap_imm", ex_imm, 32'hFFFF_FFFE);
    chk("cap_dst", {27'd0, ex_dst}, 32'd4);
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_ctrl", {24'd0, ex_ctrl}, {24'd0, C_ALU});
    chk("cap_rs", {27'd0, ex_rs}, 32'd2);

    // regdst=0 selects rt; positive immediate.
    drive(1'b1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd7, 16'h1234, C_ALUI);
    step();
    chk("rt_dst", {27'd0, ex_dst}, 32'd3);
    chk("pos_imm", ex_imm, 32'h0000_1234);

    // Write-back bypass on B, then on A, then suppressed for register 0.
    drive(1'b1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd0, 16'd0, C_ALU);
    wb_regwrite = 1'b1; wb_addr = 5'd3; wb_data = 32'd100;
    step();
    chk("byp_b", ex_b, 32'd100);
    chk("byp_b_a", ex_a, 32'd5);
    wb_addr = 5'd2; wb_data = 32'd55;
    step();
    chk("byp_a", ex_a, 32'd55);
    chk("byp_a_b", ex_b, 32'd0);
    drive(1'b1, 5'd0, 5'd3, 5'd4, 32'd9, 32'd0, 16'd0, C_ALU);
    wb_addr = 5'd0; wb_data = 32'd100;
    step();
    chk("byp_r0_b", ex_b, 32'd0);
    chk("byp_r0_a", ex_a, 32'd9);
    wb_regwrite = 1'b0;
    chk("noforce_cnt", {16'd0, bubble_cnt}, 32'd0);

    // Load to r0 in EX never stalls.
    drive(1'b1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, C_LOAD);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 32'd11, 32'd0, 16'd0, C_ALU);
    #1 chk("r0_nostall", {31'd0, stall}, 32'd0);

    // Load-use: load to r6, then consumer of r6.
    drive(1'b1, 5'd1, 5'd6, 5'd0, 32'd0, 32'd0, 16'd8, C_LOAD);
    step();
    chk("ld_dst", {27'd0, ex_dst}, 32'd6);
    drive(1'b1, 5'd6, 5'd1, 5'd7, 32'd11, 32'd22, 16'd0, C_ALU);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("lu_bub_a", ex_a, 32'd0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_stall_clr", {31'd0, stall}, 32'd0);
    step();
    chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cap_a", ex_a, 32'd11);
    chk("lu_cap_dst", {27'd0, ex_dst}, 32'd7);

    // Flush and stall together: one bubble, one count.
    drive(1'b1, 5'd1, 5'd6, 5'd0, 32'd0, 32'd0, 16'd0, C_LOAD);
    step();
    drive(1'b1, 5'd2, 5'd6, 5'd7, 32'd11, 32'd22, 16'd0, C_ALU);
    flush = 1'b1;
    #1 chk("fs_stall", {31'd0, stall}, 32'd1);
    step();
    flush = 1'b0;
    chk("fs_valid", {31'd0, ex_valid}, 32'd0);
    chk("fs_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("fs_cnt", {16'd0, bubble_cnt}, 32'd2);
    chk("fs_stall_clr", {31'd0, stall}, 32'd0);

    // Empty decode slot: bubble but no count.
    drive(1'b0, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 16'd0, C_ALU);
    step();
    chk("idle_valid", {31'd0, ex_valid}, 32'd0);
    chk("idle_cnt", {16'd0, bubble_cnt}, 32'd2);

    // Reset between edges while stalled.
    drive(1'b1, 5'd1, 5'd6, 5'd0, 32'd0, 32'd0, 16'd0, C_LOAD);
    step();
    drive(1'b1, 5'd6, 5'd1, 5'd7, 32'd11, 32'd22, 16'd0, C_ALU);
    #1 chk("rs_pre_stall", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rs_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("rs_dst", {27'd0, ex_dst}, 32'd0);
    chk("rs_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rs_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rs_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("rs_cap_a", ex_a, 32'd11);
    chk("rs_cap_dst", {27'd0, ex_dst}, 32'd7);

    // Saturation: 65534 flushes reach 0xFFFE, two more stop at 0xFFFF.
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1 chk("sat_pre", {16'd0, bubble_cnt}, 32'h0000_FFFE);
    step();
    chk("sat_hit", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    step();
    chk("sat_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
